dds_sweep_ctrl: RTL

- Sequencer for the DDS frequency control word: produces fre_k for the phase accumulator in two modes, manual key stepping and timed automatic sweep.
- Steps through the decade sequence 1 kHz to 10 MHz at 125 MHz fclk: 1–10k in 1k steps, 20k–100k, 200k–1M, 2M–10M.
- Delivers each new word to the DDS core over a valid/ready handshake.
- Includes its own key synchroniser and debouncer; the key never acts as a clock.

---
 rtl/dds_sweep_ctrl_if.sv | 9 +
 rtl/dds_sweep_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl_if.sv
// rtl/dds_sweep_ctrl_if.sv - frequency word handshake between sweep controller and DDS core
interface dds_sweep_ctrl_if;
  logic [31:0] fre_k;
  logic        fre_upd;
  logic        dds_ready;

  modport master (output fre_k, output fre_upd, input dds_ready);
  modport slave  (input fre_k, input fre_upd, output dds_ready);
endinterface

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - DDS frequency word sequencer: debounced key stepping and timed decade sweep
module dds_sweep_ctrl #(
  parameter logic [31:0] F_BASE     = 32'd34360,
  parameter int unsigned DEB_CYCLES = 2500000,
  parameter int unsigned DWELL      = 12500000,
  parameter bit          LOOP       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  input  logic mode_sel,
  input  logic sweep_start,
  input  logic sweep_stop,
  output logic busy,
  output logic sweep_done,
  dds_sweep_ctrl_if.master dds
);

  localparam logic [31:0] F_X10   = F_BASE * 32'd10;
  localparam logic [31:0] F_X100  = F_BASE * 32'd100;
  localparam logic [31:0] F_X1000 = F_BASE * 32'd1000;
  localparam logic [31:0] F_MAX   = F_BASE * 32'd10000;
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int DWL_W = $clog2(DWELL + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(DWELL - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DWELL} state_t;

  state_t           state_q, state_d;
  logic [31:0]      fre_k_q, fre_k_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DWL_W-1:0] cnt_q, cnt_d;

  logic             key_s1, key_s2, key_db, key_db_d;
  logic [DEB_W-1:0] deb_cnt;
  logic             press;

  // Key level only changes after DEB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      key_db   <= 1'b1;
      key_db_d <= 1'b1;
      deb_cnt  <= '0;
    end else begin
      key_s1   <= key_in;
      key_s2   <= key_s1;
      key_db_d <= key_db;
      if (key_s2 == key_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        key_db  <= key_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign press = key_db_d & ~key_db;

  function automatic logic [31:0] next_word(input logic [31:0] f);
    if (f < F_X10)        return f + F_BASE;
    else if (f < F_X100)  return f + F_X10;
    else if (f < F_X1000) return f + F_X100;
    else if (f < F_MAX)   return f + F_X1000;
    else                  return F_BASE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fre_k_q <= F_BASE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fre_k_q <= fre_k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fre_k_d = fre_k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mode_sel) begin
          if (sweep_start) begin
            fre_k_d = F_BASE;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_LOAD;
          end
        end else if (press) begin
          fre_k_d = next_word(fre_k_q);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // A stop here only cancels the sweep; the pending word is still delivered.
        cnt_d = '0;
        if (sweep_stop) busy_d = 1'b0;
        if (dds.dds_ready) state_d = busy_d ? ST_DWELL : ST_IDLE;
      end
      ST_DWELL: begin
        cnt_d = cnt_q + 1'b1;
        if (sweep_stop) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == DWL_LAST) begin
          if (fre_k_q != F_MAX) begin
            fre_k_d = next_word(fre_k_q);
            state_d = ST_LOAD;
          end else if (LOOP) begin
            fre_k_d = F_BASE;
            state_d = ST_LOAD;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dds.fre_k   = fre_k_q;
  assign dds.fre_upd = (state_q == ST_LOAD);
  assign busy        = busy_q;
  assign sweep_done  = done_q;

endmodule
